// File: rtl/scaler_cfg_ctrl_if.sv
// Register-side and video-snoop signals of the scaler configuration sequencer.
// The master drives configuration and strobes; the slave returns the active set and status.
interface scaler_cfg_ctrl_if #(
  parameter int STEP_WIDTH = 16
);
  logic                  cfg_wr_i;
  logic [1:0]            cfg_addr_i;
  logic [STEP_WIDTH-1:0] cfg_data_i;
  logic                  cfg_commit_i;
  logic                  vs_i;
  logic                  hs_i;
  logic                  de_i;
  logic [STEP_WIDTH-1:0] reg_h_scale_step_o;
  logic [STEP_WIDTH-1:0] reg_v_scale_step_o;
  logic [STEP_WIDTH-1:0] reg_v_scale_inline_size_o;
  logic                  apply_o;
  logic                  pending_o;
  logic [STEP_WIDTH-1:0] in_width_o;
  logic [STEP_WIDTH-1:0] in_height_o;
  logic                  size_valid_o;
  logic [2:0]            err_o;

  modport master (
    output cfg_wr_i, cfg_addr_i, cfg_data_i, cfg_commit_i, vs_i, hs_i, de_i,
    input  reg_h_scale_step_o, reg_v_scale_step_o, reg_v_scale_inline_size_o,
           apply_o, pending_o, in_width_o, in_height_o, size_valid_o, err_o
  );

  modport slave (
    input  cfg_wr_i, cfg_addr_i, cfg_data_i, cfg_commit_i, vs_i, hs_i, de_i,
    output reg_h_scale_step_o, reg_v_scale_step_o, reg_v_scale_inline_size_o,
           apply_o, pending_o, in_width_o, in_height_o, size_valid_o, err_o
  );
endinterface

// File: rtl/scaler_cfg_ctrl.sv
// Scaler configuration sequencer: shadow/active register sets swapped only between
// frames, plus measurement of the input frame size from the snooped video strobes.
module scaler_cfg_ctrl #(
  parameter int SCALE_STEP       = 128,
  parameter int LINE_IN_SIZE_MAX = 1024,
  parameter int STEP_WIDTH       = 16,
  parameter int IDLE_TIMEOUT     = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  scaler_cfg_ctrl_if.slave bus
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [STEP_WIDTH-1:0] STEP_RST   = STEP_WIDTH'(SCALE_STEP);
  localparam logic [STEP_WIDTH-1:0] INLINE_RST = STEP_WIDTH'(LINE_IN_SIZE_MAX - 1);
  localparam logic [STEP_WIDTH-1:0] INLINE_LIM = STEP_WIDTH'(LINE_IN_SIZE_MAX);
  localparam logic [STEP_WIDTH-1:0] CNT_MAX    = {STEP_WIDTH{1'b1}};
  localparam logic [IDLE_W-1:0]     IDLE_LAST  = IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_APPLY
  } state_e;

  state_e                state_q, state_d;
  logic [STEP_WIDTH-1:0] h_shadow_q, h_shadow_d;
  logic [STEP_WIDTH-1:0] v_shadow_q, v_shadow_d;
  logic [STEP_WIDTH-1:0] inl_shadow_q, inl_shadow_d;
  logic [STEP_WIDTH-1:0] h_active_q, h_active_d;
  logic [STEP_WIDTH-1:0] v_active_q, v_active_d;
  logic [STEP_WIDTH-1:0] inl_active_q, inl_active_d;
  logic                  apply_q, apply_d;
  logic                  pending_q, pending_d;
  logic [1:0]            err_cfg_q, err_cfg_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;

  logic                  vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
  logic                  hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
  logic                  de_s1_q, de_s1_d;
  logic [STEP_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
  logic [STEP_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [STEP_WIDTH-1:0] first_width_q, first_width_d;
  logic                  first_seen_q, first_seen_d;
  logic [STEP_WIDTH-1:0] in_width_q, in_width_d;
  logic [STEP_WIDTH-1:0] in_height_q, in_height_d;
  logic                  size_valid_q, size_valid_d;
  logic                  ragged_q, ragged_d;

  logic vs_rise, vs_fall, hs_rise, hs_fall;

  assign vs_rise = vs_s1_q & ~vs_s2_q;
  assign vs_fall = ~vs_s1_q & vs_s2_q;
  assign hs_rise = hs_s1_q & ~hs_s2_q;
  assign hs_fall = ~hs_s1_q & hs_s2_q;

  // Configuration FSM; a simultaneous write lands before the commit validates it.
  always_comb begin
    state_d      = state_q;
    h_shadow_d   = h_shadow_q;
    v_shadow_d   = v_shadow_q;
    inl_shadow_d = inl_shadow_q;
    h_active_d   = h_active_q;
    v_active_d   = v_active_q;
    inl_active_d = inl_active_q;
    apply_d      = 1'b0;
    pending_d    = pending_q;
    err_cfg_d    = err_cfg_q;
    idle_cnt_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_wr_i) begin
          case (bus.cfg_addr_i)
            2'd0:    h_shadow_d   = bus.cfg_data_i;
            2'd1:    v_shadow_d   = bus.cfg_data_i;
            2'd2:    inl_shadow_d = bus.cfg_data_i;
            default: ;
          endcase
        end
        if (bus.cfg_commit_i) begin
          if ((h_shadow_d != '0) && (v_shadow_d != '0) && (inl_shadow_d < INLINE_LIM)) begin
            state_d   = ST_PENDING;
            pending_d = 1'b1;
          end else begin
            err_cfg_d[0] = 1'b1;
          end
        end
      end

      ST_PENDING: begin
        if (bus.cfg_wr_i) begin
          err_cfg_d[1] = 1'b1;
        end
        if (!vs_s1_q) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (vs_fall || (!vs_s1_q && (idle_cnt_q == IDLE_LAST))) begin
          state_d   = ST_APPLY;
          apply_d   = 1'b1;
          pending_d = 1'b0;
        end
      end

      ST_APPLY: begin
        h_active_d   = h_shadow_q;
        v_active_d   = v_shadow_q;
        inl_active_d = inl_shadow_q;
        state_d      = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // Frame measurement works entirely on the registered strobes so edges and counts align.
  always_comb begin
    vs_s1_d       = bus.vs_i;
    vs_s2_d       = vs_s1_q;
    hs_s1_d       = bus.hs_i;
    hs_s2_d       = hs_s1_q;
    de_s1_d       = bus.de_i;
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    first_width_d = first_width_q;
    first_seen_d  = first_seen_q;
    in_width_d    = in_width_q;
    in_height_d   = in_height_q;
    size_valid_d  = size_valid_q;
    ragged_d      = ragged_q;

    if (hs_fall) begin
      pix_cnt_d = de_s1_q ? STEP_WIDTH'(1) : '0;
    end else if (!hs_s1_q && de_s1_q && (pix_cnt_q != CNT_MAX)) begin
      pix_cnt_d = pix_cnt_q + 1'b1;
    end

    if (vs_rise) begin
      line_cnt_d    = hs_fall ? STEP_WIDTH'(1) : '0;
      first_seen_d  = 1'b0;
      first_width_d = '0;
    end else if (hs_fall && vs_s1_q && (line_cnt_q != CNT_MAX)) begin
      line_cnt_d = line_cnt_q + 1'b1;
    end

    if (hs_rise && vs_s1_q) begin
      if (!first_seen_q || vs_rise) begin
        first_width_d = pix_cnt_q;
        first_seen_d  = 1'b1;
      end else if (pix_cnt_q != first_width_q) begin
        ragged_d = 1'b1;
      end
    end

    if (vs_fall) begin
      in_width_d   = first_width_q;
      in_height_d  = line_cnt_q;
      size_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      h_shadow_q    <= STEP_RST;
      v_shadow_q    <= STEP_RST;
      inl_shadow_q  <= INLINE_RST;
      h_active_q    <= STEP_RST;
      v_active_q    <= STEP_RST;
      inl_active_q  <= INLINE_RST;
      apply_q       <= 1'b0;
      pending_q     <= 1'b0;
      err_cfg_q     <= '0;
      idle_cnt_q    <= '0;
      vs_s1_q       <= 1'b0;
      vs_s2_q       <= 1'b0;
      hs_s1_q       <= 1'b0;
      hs_s2_q       <= 1'b0;
      de_s1_q       <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      first_width_q <= '0;
      first_seen_q  <= 1'b0;
      in_width_q    <= '0;
      in_height_q   <= '0;
      size_valid_q  <= 1'b0;
      ragged_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_shadow_q    <= h_shadow_d;
      v_shadow_q    <= v_shadow_d;
      inl_shadow_q  <= inl_shadow_d;
      h_active_q    <= h_active_d;
      v_active_q    <= v_active_d;
      inl_active_q  <= inl_active_d;
      apply_q       <= apply_d;
      pending_q     <= pending_d;
      err_cfg_q     <= err_cfg_d;
      idle_cnt_q    <= idle_cnt_d;
      vs_s1_q       <= vs_s1_d;
      vs_s2_q       <= vs_s2_d;
      hs_s1_q       <= hs_s1_d;
      hs_s2_q       <= hs_s2_d;
      de_s1_q       <= de_s1_d;
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      first_width_q <= first_width_d;
      first_seen_q  <= first_seen_d;
      in_width_q    <= in_width_d;
      in_height_q   <= in_height_d;
      size_valid_q  <= size_valid_d;
      ragged_q      <= ragged_d;
    end
  end

  assign bus.reg_h_scale_step_o        = h_active_q;
  assign bus.reg_v_scale_step_o        = v_active_q;
  assign bus.reg_v_scale_inline_size_o = inl_active_q;
  assign bus.apply_o                   = apply_q;
  assign bus.pending_o                 = pending_q;
  assign bus.in_width_o                = in_width_q;
  assign bus.in_height_o               = in_height_q;
  assign bus.size_valid_o              = size_valid_q;
  assign bus.err_o                     = {ragged_q, err_cfg_q};

endmodule
